// File: rtl/chacha_axi_pkg.sv
// Shared AXI read-side constants, reader FSM states and the AXI size encoding helper
// for the ChaCha20 DMA front end.
package chacha_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN,
    DONE
  } rd_state_t;

  function automatic logic [2:0] axi_size(input int dwidth);
    return (dwidth == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible on dout whenever not empty.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_V);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read master: fetches word_count words from base_addr in 4KB-safe INCR bursts,
// one burst outstanding, and streams them out with tlast on the final word.
module axi_burst_reader
  import chacha_axi_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int IWIDTH     = 1,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [AWIDTH-1:0]    base_addr,
  input  logic [LEN_WIDTH-1:0] word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IWIDTH-1:0]    m_arid,
  output logic [AWIDTH-1:0]    m_araddr,
  output logic [2:0]           m_arprot,
  output logic [1:0]           m_arburst,
  output logic [3:0]           m_arcache,
  output logic [7:0]           m_arlen,
  output logic [2:0]           m_arsize,
  output logic                 m_arlock,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [IWIDTH-1:0]    m_rid,
  input  logic [DWIDTH-1:0]    m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rvalid,
  input  logic                 m_rlast,
  output logic                 m_rready,
  output logic [DWIDTH-1:0]    m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready
);

  localparam int BYTES  = DWIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW     = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  rd_state_t            state;
  logic [AWIDTH-1:0]    cur_addr;
  logic [LEN_WIDTH-1:0] words_left;
  logic [8:0]           beats_left;

  logic [AWIDTH-1:0]    aligned_base;
  logic [AWIDTH-1:0]    src_addr;
  logic [LEN_WIDTH-1:0] src_words;
  logic [12:0]          page_bytes;
  logic [12:0]          page_words;
  logic [CW-1:0]        burst_beats;
  logic [7:0]           burst_len;
  logic [AWIDTH-1:0]    addr_step;

  logic [DWIDTH:0]      fifo_dout;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W-1:0]     fifo_free;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 r_fire;
  logic                 space_ok;
  logic                 unused;

  assign m_arid    = '0;
  assign m_arprot  = 3'b000;
  assign m_arburst = AXI_BURST_INCR;
  assign m_arcache = AXI_CACHE_DEFAULT;
  assign m_arsize  = axi_size(DWIDTH);
  assign m_arlock  = 1'b0;
  assign unused    = ^m_rid;

  assign aligned_base = base_addr & ~AWIDTH'(BYTES - 1);
  // In IDLE the first burst is sized straight from the request inputs.
  assign src_addr     = (state == IDLE) ? aligned_base : cur_addr;
  assign src_words    = (state == IDLE) ? word_count : words_left;
  assign page_bytes   = 13'h1000 - {1'b0, src_addr[11:0]};
  assign page_words   = page_bytes >> BSHIFT;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    burst_beats = CW'(src_words);
    if (burst_beats > CW'(MAX_BURST)) burst_beats = CW'(MAX_BURST);
    if (burst_beats > CW'(page_words)) burst_beats = CW'(page_words);
  end

  assign burst_len = 8'(burst_beats - CW'(1));
  assign addr_step = (AWIDTH'(m_arlen) + AWIDTH'(1)) << BSHIFT;
  assign fifo_free = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign space_ok  = (CW'(fifo_free) >= burst_beats);

  assign m_rready = (state == DATA) && !fifo_full;
  assign r_fire   = m_rvalid && m_rready;

  sync_fifo #(
    .WIDTH (DWIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (r_fire),
    .din    ({(words_left == LEN_WIDTH'(1)), m_rdata}),
    .pop    (m_tready),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_dout[DWIDTH-1:0];
  assign m_tlast  = fifo_dout[DWIDTH] && !fifo_empty;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      m_arvalid  <= 1'b0;
      m_araddr   <= '0;
      m_arlen    <= '0;
      cur_addr   <= '0;
      words_left <= '0;
      beats_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            err        <= 1'b0;
            cur_addr   <= aligned_base;
            words_left <= word_count;
            if (word_count == '0) begin
              state <= DONE;
            end else begin
              // FIFO is always empty here, so the first burst needs no space check.
              m_arvalid <= 1'b1;
              m_araddr  <= aligned_base;
              m_arlen   <= burst_len;
              state     <= ADDR;
            end
          end
        end
        ADDR: begin
          if (m_arvalid) begin
            if (m_arready) begin
              m_arvalid  <= 1'b0;
              cur_addr   <= cur_addr + addr_step;
              beats_left <= {1'b0, m_arlen} + 9'd1;
              state      <= DATA;
            end
          end else if (space_ok) begin
            m_arvalid <= 1'b1;
            m_araddr  <= cur_addr;
            m_arlen   <= burst_len;
          end
        end
        DATA: begin
          if (r_fire) begin
            words_left <= words_left - LEN_WIDTH'(1);
            beats_left <= beats_left - 9'd1;
            if (m_rresp != AXI_RESP_OKAY) err <= 1'b1;
            if (m_rlast != (beats_left == 9'd1)) err <= 1'b1;
            // The burst ends on our own beat count, whatever rlast claims.
            if (beats_left == 9'd1) begin
              state <= (words_left == LEN_WIDTH'(1)) ? DRAIN : ADDR;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Directed bench for axi_burst_reader: behavioural AXI read slave plus stream/AR logging,
// checking burst splitting, 4KB boundaries, back-pressure, error handling and reset.
module tb_axi_burst_reader;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done, err;
  logic [0:0]  m_arid;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arcache;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic        m_arlock;
  logic        m_arvalid;
  logic        m_arready;
  logic [0:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;

  int checks = 0;
  int errors = 0;

  bit          s_active = 1'b0;
  logic [31:0] s_addr   = '0;
  int          s_len    = 0;
  int          s_beat   = 0;
  int          r_cnt    = 0;
  int          err_at   = -1;
  int          done_cnt = 0;
  logic [31:0] ar_addr_q[$];
  int          ar_len_q[$];
  logic [31:0] t_data_q[$];
  bit          t_last_q[$];

  axi_burst_reader dut (
    .aclk       (aclk),
    .areset     (areset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .m_arid     (m_arid),
    .m_araddr   (m_araddr),
    .m_arprot   (m_arprot),
    .m_arburst  (m_arburst),
    .m_arcache  (m_arcache),
    .m_arlen    (m_arlen),
    .m_arsize   (m_arsize),
    .m_arlock   (m_arlock),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rid      (m_rid),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rvalid   (m_rvalid),
    .m_rlast    (m_rlast),
    .m_rready   (m_rready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready)
  );

  always #5 aclk = ~aclk;

  // Handshake monitor and slave state update, sampled at the active edge.
  always @(posedge aclk) begin
    if (areset) begin
      s_active = 1'b0;
    end else begin
      if (m_arvalid && m_arready) begin
        ar_addr_q.push_back(m_araddr);
        ar_len_q.push_back(int'(m_arlen));
        s_active = 1'b1;
        s_addr   = m_araddr;
        s_len    = int'(m_arlen);
        s_beat   = 0;
      end else if (m_rvalid && m_rready) begin
        r_cnt++;
        if (s_beat == s_len) s_active = 1'b0;
        else s_beat++;
      end
      if (m_tvalid && m_tready) begin
        t_data_q.push_back(m_tdata);
        t_last_q.push_back(m_tlast);
      end
      if (done) done_cnt++;
    end
  end

  // Slave outputs change on the falling edge, away from DUT sampling.
  always @(negedge aclk) begin
    m_arready = !s_active;
    m_rvalid  = s_active;
    m_rdata   = 32'hA500_0000 ^ (s_addr + 32'(4 * s_beat));
    m_rlast   = s_active && (s_beat == s_len);
    m_rresp   = (s_active && r_cnt == err_at) ? 2'b10 : 2'b00;
    m_rid     = '0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ar_addr_q.delete();
    ar_len_q.delete();
    t_data_q.delete();
    t_last_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [15:0] cnt);
    @(negedge aclk);
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    @(negedge aclk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt > 0), 1);
    repeat (4) @(negedge aclk);
    check({tag, "_done_once"}, 64'(done_cnt), 1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int n);
    int bad_d;
    int bad_l;
    bad_d = 0;
    bad_l = 0;
    check({tag, "_beats"}, 64'(t_data_q.size()), 64'(n));
    for (int i = 0; i < t_data_q.size() && i < n; i++) begin
      if (t_data_q[i] !== (32'hA500_0000 ^ (base + 32'(4 * i)))) bad_d++;
      if (t_last_q[i] !== (i == n - 1)) bad_l++;
    end
    check({tag, "_data_bad"}, 64'(bad_d), 0);
    check({tag, "_tlast_bad"}, 64'(bad_l), 0);
  endtask

  task automatic check_ar(input string tag, input int idx, input logic [31:0] addr, input int len);
    logic [31:0] a;
    int          l;
    a = (idx < ar_addr_q.size()) ? ar_addr_q[idx] : 32'hDEAD_BEEF;
    l = (idx < ar_len_q.size()) ? ar_len_q[idx] : -1;
    check({tag, "_araddr"}, 64'(a), 64'(addr));
    check({tag, "_arlen"}, 64'(l), 64'(len));
  endtask

  initial begin
    int r0;
    int n;
    areset     = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    m_tready   = 1'b1;
    repeat (3) @(negedge aclk);

    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err), 0);
    check("rst_arvalid", 64'(m_arvalid), 0);
    check("rst_rready", 64'(m_rready), 0);
    check("rst_tvalid", 64'(m_tvalid), 0);
    check("rst_tlast", 64'(m_tlast), 0);
    check("rst_araddr", 64'(m_araddr), 0);
    check("rst_arlen", 64'(m_arlen), 0);
    check("rst_arsize", 64'(m_arsize), 2);
    check("rst_arburst", 64'(m_arburst), 1);
    check("rst_arcache", 64'(m_arcache), 3);
    areset = 1'b0;
    @(negedge aclk);

    // 1: three bursts 16/16/8 words
    clear_logs();
    pulse_start(32'h0000_1000, 16'd40);
    wait_done("t1", 500);
    check("t1_ar_count", 64'(ar_addr_q.size()), 3);
    check_ar("t1_b0", 0, 32'h1000, 15);
    check_ar("t1_b1", 1, 32'h1040, 15);
    check_ar("t1_b2", 2, 32'h1080, 7);
    check_stream("t1", 32'h1000, 40);
    check("t1_err", 64'(err), 0);
    check("t1_busy", 64'(busy), 0);

    // 2: 4KB boundary split
    clear_logs();
    pulse_start(32'h0000_0FF8, 16'd8);
    wait_done("t2", 300);
    check("t2_ar_count", 64'(ar_addr_q.size()), 2);
    check_ar("t2_b0", 0, 32'h0FF8, 1);
    check_ar("t2_b1", 1, 32'h1000, 5);
    check_stream("t2", 32'h0FF8, 8);

    // 3: zero-length request
    clear_logs();
    pulse_start(32'h0000_2000, 16'd0);
    check("t3_done_c1", 64'(done), 0);
    check("t3_busy_c1", 64'(busy), 1);
    @(negedge aclk);
    check("t3_done_c2", 64'(done), 1);
    check("t3_busy_c2", 64'(busy), 0);
    @(negedge aclk);
    check("t3_done_c3", 64'(done), 0);
    repeat (3) @(negedge aclk);
    check("t3_ar_count", 64'(ar_addr_q.size()), 0);
    check("t3_beats", 64'(t_data_q.size()), 0);
    check("t3_busy_after", 64'(busy), 0);

    // 4: back-pressure fills the FIFO and stalls further bursts
    clear_logs();
    m_tready = 1'b0;
    r0 = r_cnt;
    pulse_start(32'h0000_2000, 16'd64);
    repeat (100) @(negedge aclk);
    check("t4_r_beats_stalled", 64'(r_cnt - r0), 32);
    check("t4_ar_count_stalled", 64'(ar_addr_q.size()), 2);
    check("t4_rready_full", 64'(m_rready), 0);
    check("t4_arvalid_held", 64'(m_arvalid), 0);
    check("t4_no_stream", 64'(t_data_q.size()), 0);
    check("t4_busy", 64'(busy), 1);
    m_tready = 1'b1;
    wait_done("t4", 2000);
    check("t4_ar_count", 64'(ar_addr_q.size()), 4);
    check_ar("t4_b3", 3, 32'h20C0, 15);
    check_stream("t4", 32'h2000, 64);

    // 5: SLVERR on third beat, then cleared by next start
    clear_logs();
    err_at = r_cnt + 2;
    pulse_start(32'h0000_3000, 16'd8);
    wait_done("t5a", 300);
    err_at = -1;
    check("t5_err_set", 64'(err), 1);
    check_stream("t5a", 32'h3000, 8);
    repeat (3) @(negedge aclk);
    check("t5_err_sticky", 64'(err), 1);
    clear_logs();
    pulse_start(32'h0000_3100, 16'd4);
    check("t5_err_cleared", 64'(err), 0);
    wait_done("t5b", 300);
    check("t5b_err", 64'(err), 0);
    check_stream("t5b", 32'h3100, 4);

    // 6: reset in the middle of a data phase
    clear_logs();
    r0 = r_cnt;
    pulse_start(32'h0000_4000, 16'd32);
    n = 0;
    while (r_cnt - r0 < 5 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check("t6_reached_data", 64'(r_cnt - r0 >= 5), 1);
    areset = 1'b1;
    @(negedge aclk);
    check("t6_busy", 64'(busy), 0);
    check("t6_done", 64'(done), 0);
    check("t6_err", 64'(err), 0);
    check("t6_arvalid", 64'(m_arvalid), 0);
    check("t6_rready", 64'(m_rready), 0);
    check("t6_tvalid", 64'(m_tvalid), 0);
    check("t6_tlast", 64'(m_tlast), 0);
    check("t6_araddr", 64'(m_araddr), 0);
    check("t6_arlen", 64'(m_arlen), 0);
    areset = 1'b0;
    @(negedge aclk);
    clear_logs();
    pulse_start(32'h0000_5000, 16'd4);
    wait_done("t6b", 300);
    check("t6b_ar_count", 64'(ar_addr_q.size()), 1);
    check_ar("t6b_b0", 0, 32'h5000, 3);
    check_stream("t6b", 32'h5000, 4);
    check("t6b_err", 64'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
